// File: rtl/g_aetcam_pkg.sv
// g_aetcam_pkg: shared command and state encodings for the AETCAM write side
package g_aetcam_pkg;
    typedef enum logic [1:0] {OP_WRITE, OP_INVAL, OP_CLEAR, OP_RSVD} op_e;
    typedef enum logic [2:0] {S_IDLE, S_WR, S_SWEEP, S_SETTLE, S_ERR} state_e;
endpackage

// File: rtl/g_aetcam_row_dec.sv
// g_aetcam_row_dec: row address plus enable to one-hot (or zero) row select
module g_aetcam_row_dec #(
    parameter int DEPTH = 64
) (
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic [DEPTH-1:0]         onehot
);
    localparam int AW = $clog2(DEPTH);
    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        assign onehot[i] = en && (addr == AW'(i));
    end
endmodule

// File: rtl/g_aetcam_update_ctrl.sv
// g_aetcam_update_ctrl: write-side controller driving row enables, data buses and per-row valid bits
module g_aetcam_update_ctrl
    import g_aetcam_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(DEPTH)-1:0] cmd_addr,
    input  logic [WIDTH-1:0]         cmd_value,
    input  logic [WIDTH-1:0]         cmd_mask,
    output logic [DEPTH-1:0]         cell_wen,
    output logic [WIDTH-1:0]         cell_w_st,
    output logic [WIDTH-1:0]         cell_w_m,
    output logic [DEPTH-1:0]         entry_valid,
    output logic                     search_block,
    output logic                     cmd_done,
    output logic                     cmd_err
);
    localparam int AW = $clog2(DEPTH);
    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] st_q, st_d, m_q, m_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             accept, addr_ok, last_row;
    // addr_q doubles as the sweep row counter, so one decoder serves both write paths
    g_aetcam_row_dec #(.DEPTH(DEPTH)) u_row_dec (
        .en     (state_q == S_WR || state_q == S_SWEEP),
        .addr   (addr_q),
        .onehot (cell_wen)
    );
    // state and datapath registers, synchronous active-low reset aborts any command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            st_q    <= '0;
            m_q     <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            st_q    <= st_d;
            m_q     <= m_d;
            valid_q <= valid_d;
        end
    end
    // next-state: decode accepted command, step the sweep until the last row
    always_comb begin
        accept   = cmd_valid && state_q == S_IDLE;
        addr_ok  = {1'b0, cmd_addr} < (AW + 1)'(DEPTH);
        last_row = {1'b0, addr_q} == (AW + 1)'(DEPTH - 1);
        state_d  = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = cmd_op == OP_CLEAR ? S_SWEEP :
                                           (cmd_op == OP_RSVD || !addr_ok) ? S_ERR : S_WR;
            S_WR:    state_d = S_SETTLE;
            S_SWEEP: if (last_row) state_d = S_SETTLE;
            default: state_d = S_IDLE;
        endcase
    end
    // capture command on accept; stored bits are canonicalised so masked bits are 0
    always_comb begin
        addr_d = addr_q;
        wr_d   = wr_q;
        st_d   = st_q;
        m_d    = m_q;
        if (accept) begin
            addr_d = cmd_op == OP_CLEAR ? '0 : cmd_addr;
            wr_d   = cmd_op == OP_WRITE;
            st_d   = cmd_op == OP_WRITE ? cmd_value & ~cmd_mask : '0;
            m_d    = cmd_op == OP_WRITE ? cmd_mask : '0;
        end else if (state_q == S_SWEEP) begin
            addr_d = addr_q + 1'b1;
        end
        valid_d = (state_q == S_WR && wr_q) ? valid_q | cell_wen : valid_q & ~cell_wen;
    end
    // outputs decoded from state; data buses only carry data while a write is in flight
    always_comb begin
        cmd_ready    = state_q == S_IDLE;
        search_block = state_q == S_WR || state_q == S_SWEEP || state_q == S_SETTLE;
        cmd_done     = state_q == S_SETTLE;
        cmd_err      = state_q == S_ERR;
        cell_w_st    = state_q == S_WR ? st_q : '0;
        cell_w_m     = state_q == S_WR ? m_q : '0;
        entry_valid  = valid_q;
    end
endmodule

// File: tb/tb_g_aetcam_update_ctrl.sv
// tb_g_aetcam_update_ctrl: table, random and corner-case checks against a row-array reference model
module tb_g_aetcam_update_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_valid48;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_value, cmd_mask;
    logic        cmd_ready, search_block, cmd_done, cmd_err;
    logic [63:0] cell_wen, entry_valid;
    logic [31:0] cell_w_st, cell_w_m;
    logic        ready48, sb48, done48, err48;
    logic [47:0] wen48, ev48;
    logic [31:0] st48, m48;

    int checks = 0;
    int errors = 0;
    bit        mv[64];
    logic [31:0] cst[64], cm[64];

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  addr;
        logic [31:0] val, msk, exp_st, exp_m;
    } vec_t;
    vec_t tbl[8];

    g_aetcam_update_ctrl #(.DEPTH(64), .WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_mask(cmd_mask),
        .cell_wen(cell_wen), .cell_w_st(cell_w_st), .cell_w_m(cell_w_m),
        .entry_valid(entry_valid), .search_block(search_block),
        .cmd_done(cmd_done), .cmd_err(cmd_err)
    );

    g_aetcam_update_ctrl #(.DEPTH(48), .WIDTH(32)) dut48 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid48), .cmd_ready(ready48),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_mask(cmd_mask),
        .cell_wen(wen48), .cell_w_st(st48), .cell_w_m(m48),
        .entry_valid(ev48), .search_block(sb48),
        .cmd_done(done48), .cmd_err(err48)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model_ev();
        logic [63:0] v = '0;
        for (int r = 0; r < 64; r++) v[r] = mv[r];
        return v;
    endfunction

    // issue one command on the 64-row DUT and check its whole cycle-by-cycle trace
    task automatic do_cmd(input logic [1:0] op, input logic [5:0] addr,
                          input logic [31:0] val, input logic [31:0] msk,
                          input logic [31:0] exp_st, input logic [31:0] exp_m);
        int n, row, w;
        w = 0;
        while (!cmd_ready && w < 200) begin tick(); w++; end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_addr = addr; cmd_value = val; cmd_mask = msk;
        tick();
        cmd_valid = 0;
        if (op == 2'd3) begin
            check("err_pulse", cmd_err, 1);
            check("err_no_wen", cell_wen, 0);
            check("err_ev", entry_valid, model_ev());
            check("err_sb", search_block, 0);
            check("err_done", cmd_done, 0);
            tick();
            check("err_ready", cmd_ready, 1);
            check("err_pulse_end", cmd_err, 0);
            return;
        end
        n = (op == 2'd2) ? 64 : 1;
        for (int k = 0; k < n; k++) begin
            row = (op == 2'd2) ? k : int'(addr);
            check("wen", cell_wen, 64'(1) << row);
            check("w_st", cell_w_st, (op == 2'd2) ? 32'h0 : exp_st);
            check("w_m", cell_w_m, (op == 2'd2) ? 32'h0 : exp_m);
            check("sb_write", search_block, 1);
            check("busy_ready", cmd_ready, 0);
            check("done_early", cmd_done, 0);
            cst[row] = cell_w_st;
            cm[row]  = cell_w_m;
            tick();
        end
        if (op == 2'd0) mv[addr] = 1'b1;
        else if (op == 2'd1) mv[addr] = 1'b0;
        else for (int r = 0; r < 64; r++) mv[r] = 1'b0;
        check("done", cmd_done, 1);
        check("settle_wen", cell_wen, 0);
        check("sb_settle", search_block, 1);
        check("ev_after", entry_valid, model_ev());
        check("settle_ready", cmd_ready, 0);
        tick();
        check("ready_after", cmd_ready, 1);
        check("done_end", cmd_done, 0);
        check("sb_idle", search_block, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  op;
        logic [5:0]  a;
        logic [31:0] v, m;
        int acc[3];
        int idx, cyc, w, r;
        logic [5:0] b2b_addr[3];
        bit found;

        tbl[0] = '{2'd0, 6'd0,  32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000};
        tbl[1] = '{2'd0, 6'd31, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        tbl[2] = '{2'd0, 6'd63, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[3] = '{2'd1, 6'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
        tbl[4] = '{2'd1, 6'd31, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[5] = '{2'd0, 6'd31, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hF0F0_F0F0};
        tbl[6] = '{2'd0, 6'd7,  32'h8000_0001, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001};
        tbl[7] = '{2'd0, 6'd7,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00F0, 32'h0000_000F};

        rst_n = 0; cmd_valid = 0; cmd_valid48 = 0;
        cmd_op = 0; cmd_addr = 0; cmd_value = 0; cmd_mask = 0;
        for (int i = 0; i < 64; i++) begin mv[i] = 0; cst[i] = 0; cm[i] = 0; end
        tick(); tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_wen", cell_wen, 0);
        check("rst_ev", entry_valid, 0);
        check("rst_sb", search_block, 0);
        check("rst_done", cmd_done, 0);
        check("rst_err", cmd_err, 0);
        check("rst_st", cell_w_st, 0);
        check("rst_m", cell_w_m, 0);
        rst_n = 1;
        tick();

        do_cmd(2'd0, 6'd5, 32'hA5A5_00FF, 32'h0000_FF0F, 32'hA5A5_00F0, 32'h0000_FF0F);
        check("search_row5", (((32'hA5A5_12F3 & ~cm[5]) == cst[5]) && entry_valid[5]), 1);
        do_cmd(2'd1, 6'd5, 32'h0, 32'h0, 32'h0, 32'h0);
        check("inval_row5", entry_valid[5], 0);

        for (int i = 0; i < 8; i++)
            do_cmd(tbl[i].op, tbl[i].addr, tbl[i].val, tbl[i].msk, tbl[i].exp_st, tbl[i].exp_m);

        check("pre_clear_ev", entry_valid, (64'(1) << 0) | (64'(1) << 7) | (64'(1) << 31) | (64'(1) << 63));
        do_cmd(2'd2, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("clear_ev", entry_valid, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            op = r < 5 ? 2'd0 : r < 8 ? 2'd1 : r == 8 ? 2'd2 : 2'd3;
            a = 6'($urandom_range(0, 63));
            v = $urandom;
            m = $urandom;
            do_cmd(op, a, v, m, op == 2'd0 ? v & ~m : 32'h0, op == 2'd0 ? m : 32'h0);
        end

        b2b_addr[0] = 6'd10; b2b_addr[1] = 6'd20; b2b_addr[2] = 6'd30;
        idx = 0; cyc = 0;
        cmd_valid = 1; cmd_op = 2'd0; cmd_addr = b2b_addr[0];
        cmd_value = 32'h1111_0000; cmd_mask = 32'h0;
        while (idx < 3 && cyc < 30) begin
            if (cmd_ready) begin acc[idx] = cyc; idx++; end
            check("b2b_onehot", $countones(cell_wen) <= 1, 1);
            tick(); cyc++;
            if (idx < 3) cmd_addr = b2b_addr[idx];
        end
        cmd_valid = 0;
        check("b2b_all_accepted", idx, 3);
        check("b2b_gap1", acc[1] - acc[0], 3);
        check("b2b_gap2", acc[2] - acc[1], 3);
        for (int k = 0; k < 3; k++) begin
            check("b2b_onehot_tail", $countones(cell_wen) <= 1, 1);
            tick();
        end
        for (int k = 0; k < 3; k++) mv[b2b_addr[k]] = 1'b1;
        check("b2b_ev", entry_valid, model_ev());

        cmd_valid48 = 1; cmd_op = 2'd0; cmd_addr = 6'd47; cmd_value = 32'hCAFE_F00D; cmd_mask = 0;
        tick();
        cmd_valid48 = 0;
        tick(); tick();
        check("d48_ready", ready48, 1);
        check("d48_ev", ev48, 64'(1) << 47);
        for (int k = 0; k < 2; k++) begin
            cmd_valid48 = 1;
            cmd_op = k == 0 ? 2'd0 : 2'd3;
            cmd_addr = k == 0 ? 6'd50 : 6'd3;
            tick();
            cmd_valid48 = 0;
            check("d48_err", err48, 1);
            check("d48_err_wen", wen48, 0);
            check("d48_err_ready", ready48, 0);
            check("d48_err_done", done48, 0);
            check("d48_err_sb", sb48, 0);
            tick();
            check("d48_ready_after", ready48, 1);
            check("d48_err_end", err48, 0);
            check("d48_ev_kept", ev48, 64'(1) << 47);
        end

        w = 0;
        while (!cmd_ready && w < 10) begin tick(); w++; end
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0;
        found = 0;
        w = 0;
        while (!found && w < 100) begin
            if (cell_wen == (64'(1) << 20)) found = 1;
            else begin tick(); w++; end
        end
        check("sweep_reached_row20", found, 1);
        rst_n = 0;
        tick();
        for (int i = 0; i < 64; i++) mv[i] = 0;
        check("abort_ready", cmd_ready, 1);
        check("abort_wen", cell_wen, 0);
        check("abort_ev", entry_valid, model_ev());
        check("abort_sb", search_block, 0);
        check("abort_done", cmd_done, 0);
        check("abort_st", cell_w_st, 0);
        rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_abort_done", cmd_done, 0);
            check("post_abort_ready", cmd_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
